ysyx_22050019_ifu_fetch: RTL

- Instruction fetch stage, directly upstream of the decode stage; owns the PC.
- Issues one read per instruction on a 64-bit valid/ready memory read channel and selects the 32-bit word using pc[2].
- Presents {inst, pc} to decode through a valid/ready handshake.
- Accepts a redirect (jump/branch/trap target) from downstream at any cycle; in-flight or held work is squashed cleanly.

---
 rtl/ysyx_22050019_ifu_fetch_pkg.sv | 19 +
 rtl/ysyx_22050019_pc_reg.sv | 33 +++
 rtl/ysyx_22050019_ifu_fetch.sv | 112 +++++++++++
 3 files changed

// File: rtl/ysyx_22050019_ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ysyx_22050019_ifu_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;
    localparam logic [1:0]  RESP_OK      = 2'b00;

    function automatic logic [63:0] align8(input logic [63:0] a);
        return a & ~64'h7;
    endfunction

endpackage

// File: rtl/ysyx_22050019_pc_reg.sv
// Program counter with next-pc select: redirect target or sequential pc+4.
module ysyx_22050019_pc_reg
    import ysyx_22050019_ifu_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic        advance,
    input  logic [63:0] redirect_pc,
    output logic [63:0] pc,
    output logic [63:0] pc_next
);

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = redirect_pc & ~64'h3;
        end else if (advance) begin
            pc_next = pc + 64'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/ysyx_22050019_ifu_fetch.sv
// Instruction fetch stage: owns the pc, one outstanding 64-bit read at a time,
// hands {inst, pc} to decode over valid/ready and squashes work on redirect.
module ysyx_22050019_ifu_fetch
    import ysyx_22050019_ifu_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEF,
    parameter int          DATA_W   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [63:0]       redirect_pc,
    output logic [63:0]       mem_araddr,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        mem_rresp,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       inst_o,
    output logic [63:0]       pc_o,
    output logic              inst_err_o
);

    fetch_state_t state;
    logic         drop;
    logic [63:0]  pc;
    logic [63:0]  pc_next;
    logic         advance;

    // Sequential step only on an accepted handshake without a jump.
    assign advance = (state == S_HOLD) && out_ready && !redirect_valid;

    ysyx_22050019_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect_valid),
        .advance     (advance),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .pc_next     (pc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            drop        <= 1'b0;
            mem_arvalid <= 1'b0;
            mem_araddr  <= align8(RESET_PC);
            mem_rready  <= 1'b0;
            out_valid   <= 1'b0;
            inst_o      <= INST_NOP;
            pc_o        <= '0;
            inst_err_o  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state       <= S_ADDR;
                    mem_arvalid <= 1'b1;
                    mem_araddr  <= align8(pc_next);
                end
                S_ADDR: begin
                    // Presented address stays put; the old response is dropped.
                    if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                    if (mem_arready) begin
                        state       <= S_DATA;
                        mem_arvalid <= 1'b0;
                        mem_rready  <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (mem_rvalid) begin
                        mem_rready <= 1'b0;
                        if (drop || redirect_valid) begin
                            drop        <= 1'b0;
                            state       <= S_ADDR;
                            mem_arvalid <= 1'b1;
                            mem_araddr  <= align8(pc_next);
                        end else begin
                            state      <= S_HOLD;
                            out_valid  <= 1'b1;
                            inst_o     <= pc[2] ? mem_rdata[63:32]
                                                : mem_rdata[31:0];
                            pc_o       <= pc;
                            inst_err_o <= (mem_rresp != RESP_OK);
                        end
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready || redirect_valid) begin
                        state       <= S_ADDR;
                        out_valid   <= 1'b0;
                        mem_arvalid <= 1'b1;
                        mem_araddr  <= align8(pc_next);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
